// File: rtl/mem_burst_responder_if.sv
// Request/response bundle for the burst read responder.
// The fill engine drives the master side; the responder is the slave.
interface mem_burst_responder_if #(
  parameter int ADDR_BITS = 14
);
  logic                 MEM_RDEN1;
  logic [ADDR_BITS-1:0] MEM_ADDR1;
  logic                 MEM_WE2;
  logic [ADDR_BITS-1:0] MEM_ADDR2;
  logic [31:0]          MEM_DIN2;
  logic [31:0]          MEM_DOUT1;
  logic                 memValid1;

  modport master (
    output MEM_RDEN1,
    output MEM_ADDR1,
    output MEM_WE2,
    output MEM_ADDR2,
    output MEM_DIN2,
    input  MEM_DOUT1,
    input  memValid1
  );

  modport slave (
    input  MEM_RDEN1,
    input  MEM_ADDR1,
    input  MEM_WE2,
    input  MEM_ADDR2,
    input  MEM_DIN2,
    output MEM_DOUT1,
    output memValid1
  );
endinterface

// File: rtl/mem_burst_responder.sv
// Slow backing-store model: fixed first-access latency, then a
// wrapping burst of consecutive words; backdoor port for preload.
module mem_burst_responder #(
  parameter int DELAY_BITS = 3,
  parameter int BURST_LEN  = 8,
  parameter int ADDR_BITS  = 14
) (
  input logic                  MEM_CLK,
  input logic                  RST,
  mem_burst_responder_if.slave bus
);

  localparam int BW    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int DEPTH = 2 ** ADDR_BITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_BURST
  } state_e;

  state_e                state_q, state_d;
  logic [DELAY_BITS-1:0] dly_q, dly_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic [ADDR_BITS-1:0]  base_q, base_d;
  logic [ADDR_BITS-1:0]  rd_addr;
  logic                  rd_en;
  logic                  valid_q, valid_d;
  logic [31:0]           dout_q;
  logic [31:0]           mem_q [DEPTH];

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    beat_d  = beat_q;
    base_d  = base_q;
    valid_d = 1'b0;
    rd_en   = 1'b0;
    rd_addr = base_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.MEM_RDEN1) begin
          base_d  = bus.MEM_ADDR1;
          dly_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        dly_d = dly_q + 1'b1;
        if (!bus.MEM_RDEN1) begin
          state_d = S_IDLE;
        end else if (dly_q == '1) begin
          state_d = S_BURST;
          beat_d  = '0;
          valid_d = 1'b1;
          rd_en   = 1'b1;
          rd_addr = base_q;
        end
      end
      S_BURST: begin
        if (beat_q == BW'(BURST_LEN - 1)) begin
          state_d = S_IDLE;
        end else begin
          beat_d  = beat_q + 1'b1;
          valid_d = 1'b1;
          rd_en   = 1'b1;
          // Address arithmetic wraps naturally at the array top.
          rd_addr = base_q + ADDR_BITS'(beat_d);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge MEM_CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      dly_q   <= '0;
      beat_q  <= '0;
      base_q  <= '0;
      valid_q <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      beat_q  <= beat_d;
      base_q  <= base_d;
      valid_q <= valid_d;
      if (rd_en) begin
        dout_q <= mem_q[rd_addr];
      end
    end
  end

  // Backdoor writes ignore reset; reads on the same edge see old data.
  always_ff @(posedge MEM_CLK) begin
    if (bus.MEM_WE2) begin
      mem_q[bus.MEM_ADDR2] <= bus.MEM_DIN2;
    end
  end

  assign bus.MEM_DOUT1 = dout_q;
  assign bus.memValid1 = valid_q;

endmodule

// File: tb/tb_mem_burst_responder.sv
// Directed bench for mem_burst_responder: latency, bursts, wrap,
// abort, mid-burst reset and same-edge write collision.
module tb_mem_burst_responder;

  typedef logic [31:0] beats_t [8];

  logic   clk = 1'b0;
  logic   rst;
  int     passed = 0;
  int     total  = 0;
  beats_t bv;

  mem_burst_responder_if #(.ADDR_BITS(14)) bus ();

  mem_burst_responder #(
    .DELAY_BITS(3),
    .BURST_LEN (8),
    .ADDR_BITS (14)
  ) dut (
    .MEM_CLK(clk),
    .RST    (rst),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Called just after the edge that sampled the request.
  task automatic burst(input string tag,
                       input beats_t e,
                       input int wr_beat,
                       input logic [13:0] wa,
                       input logic [31:0] wd,
                       input logic [13:0] nxt);
    for (int i = 1; i < 8; i++) begin
      step();
      chk($sformatf("%s_wait%0d", tag, i), {31'b0, bus.memValid1}, 32'd0);
    end
    for (int k = 0; k < 8; k++) begin
      if (k == wr_beat) begin
        bus.MEM_WE2   = 1'b1;
        bus.MEM_ADDR2 = wa;
        bus.MEM_DIN2  = wd;
      end
      step();
      bus.MEM_WE2 = 1'b0;
      chk($sformatf("%s_v%0d", tag, k), {31'b0, bus.memValid1}, 32'd1);
      chk($sformatf("%s_d%0d", tag, k), bus.MEM_DOUT1, e[k]);
    end
    bus.MEM_ADDR1 = nxt;
    step();
    chk($sformatf("%s_end", tag), {31'b0, bus.memValid1}, 32'd0);
  endtask

  initial begin
    rst           = 1'b1;
    bus.MEM_RDEN1 = 1'b0;
    bus.MEM_ADDR1 = '0;
    bus.MEM_WE2   = 1'b1;
    bus.MEM_ADDR2 = '0;
    bus.MEM_DIN2  = '0;

    // Preload while in reset; writes are honoured during reset.
    for (int i = 0; i < 32; i++) begin
      bus.MEM_ADDR2 = 14'(i);
      bus.MEM_DIN2  = 32'h1000_0000 + 32'(i);
      step();
    end
    bus.MEM_WE2 = 1'b0;
    step();
    step();
    chk("rst_valid", {31'b0, bus.memValid1}, 32'd0);
    chk("rst_dout", bus.MEM_DOUT1, 32'd0);

    // Base 0, request held high; back-to-back into base 5, then 20.
    rst           = 1'b0;
    bus.MEM_RDEN1 = 1'b1;
    bus.MEM_ADDR1 = 14'd0;
    step();
    bv = '{32'h1000_0000, 32'h1000_0001, 32'h1000_0002, 32'h1000_0003,
           32'h1000_0004, 32'h1000_0005, 32'h1000_0006, 32'h1000_0007};
    burst("b0", bv, -1, 14'd0, 32'd0, 14'd5);
    step();
    bv = '{32'h1000_0005, 32'h1000_0006, 32'h1000_0007, 32'h1000_0008,
           32'h1000_0009, 32'h1000_000A, 32'h1000_000B, 32'h1000_000C};
    burst("b5", bv, -1, 14'd0, 32'd0, 14'd20);
    step();
    bv = '{32'h1000_0014, 32'h1000_0015, 32'h1000_0016, 32'h1000_0017,
           32'h1000_0018, 32'h1000_0019, 32'h1000_001A, 32'h1000_001B};
    burst("b20", bv, -1, 14'd0, 32'd0, 14'd0);
    bus.MEM_RDEN1 = 1'b0;

    // Wrap at the top of the array.
    bus.MEM_WE2   = 1'b1;
    bus.MEM_ADDR2 = 14'h3FFE;
    bus.MEM_DIN2  = 32'hAAAA_0001;
    step();
    bus.MEM_ADDR2 = 14'h3FFF;
    bus.MEM_DIN2  = 32'hAAAA_0002;
    step();
    bus.MEM_ADDR2 = 14'h0000;
    bus.MEM_DIN2  = 32'hBBBB_0000;
    step();
    bus.MEM_WE2   = 1'b0;
    bus.MEM_ADDR1 = 14'h3FFE;
    bus.MEM_RDEN1 = 1'b1;
    step();
    bv = '{32'hAAAA_0001, 32'hAAAA_0002, 32'hBBBB_0000, 32'h1000_0001,
           32'h1000_0002, 32'h1000_0003, 32'h1000_0004, 32'h1000_0005};
    burst("wrap", bv, -1, 14'd0, 32'd0, 14'h3FFE);
    bus.MEM_RDEN1 = 1'b0;

    // Abort in WAIT: request high for three sampling edges only.
    bus.MEM_ADDR1 = 14'd0;
    bus.MEM_RDEN1 = 1'b1;
    step();
    step();
    step();
    bus.MEM_RDEN1 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("abort_v%0d", i), {31'b0, bus.memValid1}, 32'd0);
      chk($sformatf("abort_d%0d", i), bus.MEM_DOUT1, 32'h1000_0005);
    end

    // Reset during beat 3, then a full fresh burst.
    bus.MEM_WE2   = 1'b1;
    bus.MEM_ADDR2 = 14'd0;
    bus.MEM_DIN2  = 32'h1000_0000;
    step();
    bus.MEM_WE2   = 1'b0;
    bus.MEM_ADDR1 = 14'd0;
    bus.MEM_RDEN1 = 1'b1;
    step();
    for (int i = 1; i < 8; i++) begin
      step();
      chk($sformatf("mr_wait%0d", i), {31'b0, bus.memValid1}, 32'd0);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("mr_v%0d", k), {31'b0, bus.memValid1}, 32'd1);
      chk($sformatf("mr_d%0d", k), bus.MEM_DOUT1, 32'h1000_0000 + 32'(k));
    end
    rst = 1'b1;
    step();
    chk("mr_rst_valid", {31'b0, bus.memValid1}, 32'd0);
    chk("mr_rst_dout", bus.MEM_DOUT1, 32'd0);
    rst = 1'b0;
    step();
    bv = '{32'h1000_0000, 32'h1000_0001, 32'h1000_0002, 32'h1000_0003,
           32'h1000_0004, 32'h1000_0005, 32'h1000_0006, 32'h1000_0007};
    burst("post_rst", bv, -1, 14'd0, 32'd0, 14'd0);

    // Write mem[2] on the beat-2 edge; repeat burst sees the new word.
    step();
    burst("coll1", bv, 2, 14'd2, 32'hDEAD_BEEF, 14'd0);
    step();
    bv[2] = 32'hDEAD_BEEF;
    burst("coll2", bv, -1, 14'd0, 32'd0, 14'd0);
    bus.MEM_RDEN1 = 1'b0;
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_burst_responder.md
# mem_burst_responder

Read-responder for the instruction-side memory port: answers a single `MEM_RDEN1` request with a fixed first-access latency, then streams `BURST_LEN` consecutive words, one per cycle, under `memValid1`. It sits behind the cache line-fill path and models the slow backing store that the fill engine initiates reads against. A word-wide backdoor write port preloads and patches contents.

## Interface
- `DELAY_BITS`, 3: first-access latency is 2**`DELAY_BITS` cycles.
- `BURST_LEN`, 8: words per burst; power of two, at least 2.
- `ADDR_BITS`, 14: word-address width; the array holds 2**`ADDR_BITS` 32-bit words.

- `MEM_CLK`  in  1  clock; all state changes on its rising edge.
- `RST`  in  1  reset; synchronous and active-high.
- `MEM_RDEN1`  in  1  read request / hold.
- `MEM_ADDR1`  in  `ADDR_BITS`  word address of the first burst word.
- `MEM_WE2`  in  1  backdoor word write enable.
- `MEM_ADDR2`  in  `ADDR_BITS`  backdoor write word address.
- `MEM_DIN2`  in  32  backdoor write data.
- `MEM_DOUT1`  out  32  burst data, registered.
- `memValid1`  out  1  `MEM_DOUT1` holds a valid burst beat, registered.

## Operation
- States: IDLE, WAIT, BURST.
- Reset, from any state including mid-burst: state to IDLE, delay and beat counters to 0, `memValid1`=0, `MEM_DOUT1`=0. Array contents are retained.
- IDLE:
  - `memValid1`=0.
  - On `MEM_RDEN1`=1, latch `MEM_ADDR1` as base, clear the delay counter, and go to WAIT.
- WAIT:
  - Delay counter increments each cycle.
  - If `MEM_RDEN1`=0, abort to IDLE; nothing is output.
  - When the counter equals 2**`DELAY_BITS`-1 and `MEM_RDEN1`=1, go to BURST with beat 0: `MEM_DOUT1` = mem[base] and `memValid1`=1.
- BURST:
  - Beat k presents mem[(base+k) mod 2**`ADDR_BITS`]; the address wraps at the top of the array.
  - `MEM_RDEN1` and `MEM_ADDR1` are ignored; the burst always completes.
  - After beat `BURST_LEN`-1, go to IDLE with `memValid1`=0.
- `MEM_DOUT1` holds its last value whenever `memValid1`=0.
- Backdoor write: mem[`MEM_ADDR2`] = `MEM_DIN2` on any edge with `MEM_WE2`=1, in every state, including during reset.
- Same-cycle write and read of one word: the read returns the old data. The written value is visible from the next edge onward, including later beats of the same burst.

## Timing
- Edge T0 samples `MEM_RDEN1`=1 in IDLE.
- `memValid1` rises at edge T0+2**`DELAY_BITS` (T0+8 at default) with beat 0.
- Beats are on edges T0+8 … T0+15 at default; `memValid1` stays high continuously, with no gaps.
- At edge T0+16 `memValid1` falls and the state is IDLE.
- The earliest edge to sample a new request is T0+17. `memValid1` is therefore low for at least one cycle between bursts.
- `MEM_RDEN1` held high continuously gives back-to-back bursts every `BURST_LEN`+2**`DELAY_BITS`+1 cycles.
- Each new burst uses the `MEM_ADDR1` value present at its own IDLE sampling edge.
- `MEM_RDEN1` dropped in WAIT at edge T0+3: state is IDLE at T0+3 and `memValid1` never rises.
- `RST` sampled high during BURST: `memValid1`=0 and `MEM_DOUT1`=0 from the next edge, with no remaining beats.

## Test plan
- Preload mem[i]=0x1000_0000+i for i=0..31. Assert `RST` for 2 cycles, then request base 0 with `MEM_RDEN1` held high. Required: `memValid1` rises 8 cycles after the sampling edge, and the beats are 0x1000_0000 … 0x1000_0007 on 8 consecutive cycles.
- Same preload, base 5, `RST` deasserted. Required: beats 0x1000_0005 … 0x1000_000C, then `memValid1`=0 for exactly 1 cycle. The next burst starts from whatever `MEM_ADDR1` holds at that sampling edge.
- Wrap-around: mem[0x3FFE]=0xAAAA_0001, mem[0x3FFF]=0xAAAA_0002, mem[0]=0xBBBB_0000. Base 0x3FFE. Required: beats 0xAAAA_0001, 0xAAAA_0002, 0xBBBB_0000, and so on.
- Abort: assert `MEM_RDEN1` for 3 cycles, then drop it. Required: `memValid1` stays 0 for the following 20 cycles and `MEM_DOUT1` is unchanged.
- Reset mid-burst: assert `RST` during beat 3. Required: `memValid1`=0 and `MEM_DOUT1`=0 on the next edge, and a fresh request afterwards returns the full burst with array contents intact.
- Write collision: write mem[2]=0xDEAD_BEEF on the beat-2 edge of a base-0 burst. Required: beat 2 shows the old value 0x1000_0002, and a repeat burst shows 0xDEAD_BEEF at beat 2.
